// File: rtl/traceback_engine.sv
// Viterbi traceback: buffers TB_DEPTH survivor words, traces back from the chosen end
// state, then holds the decoded block and the chain-in state until the consumer takes it.
//
// state | meaning
// FILL  | accepting survivor words; a start is taken only once the buffer was already full
// TRACE | walking one trellis step per cycle from the newest entry to the oldest
// OUT   | decoded block valid, waiting for i_ready
module traceback_engine #(
   parameter int STATE_W  = 4,
   parameter int TB_DEPTH = 16,
   parameter int OUT_BITS = 2
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            i_surv_valid,
   output logic                            o_surv_ready,
   input  logic [(2**STATE_W)*STATE_W-1:0] i_surv_prv_st,
   input  logic                            i_tb_start,
   input  logic [STATE_W-1:0]              i_sel_node,
   input  logic                            i_zero_term,
   output logic                            o_busy,
   output logic                            o_valid,
   input  logic                            i_ready,
   output logic [TB_DEPTH*OUT_BITS-1:0]    o_decoder_data,
   output logic [STATE_W-1:0]              o_final_node
);

   localparam int STATE_NUM = 2**STATE_W;
   localparam int IDX_W     = $clog2(TB_DEPTH);
   localparam int FILL_W    = $clog2(TB_DEPTH + 1);
   localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(TB_DEPTH - 1);
   localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(TB_DEPTH);

   typedef enum logic [1:0] {FILL, TRACE, OUT} state_t;

   state_t                                 state_q, state_d;
   logic [FILL_W-1:0]                      fill_q, fill_d;
   logic [IDX_W-1:0]                       idx_q, idx_d;
   logic [STATE_W-1:0]                     node_q, node_d;
   logic                                   busy_q, busy_d;
   logic                                   valid_q, valid_d;
   logic [TB_DEPTH-1:0][OUT_BITS-1:0]      data_q, data_d;
   logic [STATE_W-1:0]                     final_q, final_d;
   logic [STATE_NUM-1:0][STATE_W-1:0]      mem_q [TB_DEPTH];

   logic               full;
   logic               surv_ready;
   logic               wr_en;
   logic [STATE_W-1:0] nxt_node;

   assign full       = (fill_q == FILL_MAX);
   assign surv_ready = (state_q == FILL) && !full;
   assign nxt_node   = mem_q[idx_q][node_q];

   always_comb begin
      state_d = state_q;
      fill_d  = fill_q;
      idx_d   = idx_q;
      node_d  = node_q;
      busy_d  = busy_q;
      valid_d = valid_q;
      data_d  = data_q;
      final_d = final_q;
      wr_en   = 1'b0;
      case (state_q)
         FILL: begin
            if (i_surv_valid && surv_ready) begin
               wr_en  = 1'b1;
               fill_d = fill_q + FILL_W'(1);
            end
            // full is the pre-edge fill, so a start landing with the last write is dropped
            if (i_tb_start && full) begin
               node_d  = i_zero_term ? '0 : i_sel_node;
               idx_d   = IDX_LAST;
               busy_d  = 1'b1;
               state_d = TRACE;
            end
         end
         TRACE: begin
            data_d[idx_q] = node_q[OUT_BITS-1:0];
            node_d        = nxt_node;
            if (idx_q == '0) begin
               final_d = nxt_node;
               valid_d = 1'b1;
               state_d = OUT;
            end else begin
               idx_d = idx_q - IDX_W'(1);
            end
         end
         OUT: begin
            if (i_ready) begin
               valid_d = 1'b0;
               busy_d  = 1'b0;
               fill_d  = '0;
               state_d = FILL;
            end
         end
         default: state_d = FILL;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= FILL;
         fill_q  <= '0;
         idx_q   <= '0;
         node_q  <= '0;
         busy_q  <= 1'b0;
         valid_q <= 1'b0;
         data_q  <= '0;
         final_q <= '0;
      end else begin
         state_q <= state_d;
         fill_q  <= fill_d;
         idx_q   <= idx_d;
         node_q  <= node_d;
         busy_q  <= busy_d;
         valid_q <= valid_d;
         data_q  <= data_d;
         final_q <= final_d;
      end
   end

   // Survivor storage needs no reset; fill tracks which entries are meaningful.
   always_ff @(posedge clk) begin
      if (!rst && wr_en) begin
         mem_q[fill_q[IDX_W-1:0]] <= i_surv_prv_st;
      end
   end

   assign o_surv_ready   = surv_ready;
   assign o_busy         = busy_q;
   assign o_valid        = valid_q;
   assign o_decoder_data = data_q;
   assign o_final_node   = final_q;

endmodule

// File: tb/tb_traceback_engine.sv
// Directed bench for traceback_engine at TB_DEPTH=4: identity and shift maps, start timing,
// back-pressure, zero-termination and mid-trace reset.
module tb_traceback_engine;

   localparam int STATE_W  = 4;
   localparam int TB_DEPTH = 4;
   localparam int OUT_BITS = 2;
   localparam int PRV_W    = (2**STATE_W)*STATE_W;

   logic                         clk = 1'b0;
   logic                         rst = 1'b1;
   logic                         i_surv_valid = 1'b0;
   logic                         o_surv_ready;
   logic [PRV_W-1:0]             i_surv_prv_st = '0;
   logic                         i_tb_start = 1'b0;
   logic [STATE_W-1:0]           i_sel_node = '0;
   logic                         i_zero_term = 1'b0;
   logic                         o_busy;
   logic                         o_valid;
   logic                         i_ready = 1'b0;
   logic [TB_DEPTH*OUT_BITS-1:0] o_decoder_data;
   logic [STATE_W-1:0]           o_final_node;

   int vec_cnt = 0;
   int err_cnt = 0;

   traceback_engine #(
      .STATE_W (STATE_W),
      .TB_DEPTH(TB_DEPTH),
      .OUT_BITS(OUT_BITS)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .i_surv_valid  (i_surv_valid),
      .o_surv_ready  (o_surv_ready),
      .i_surv_prv_st (i_surv_prv_st),
      .i_tb_start    (i_tb_start),
      .i_sel_node    (i_sel_node),
      .i_zero_term   (i_zero_term),
      .o_busy        (o_busy),
      .o_valid       (o_valid),
      .i_ready       (i_ready),
      .o_decoder_data(o_decoder_data),
      .o_final_node  (o_final_node)
   );

   always #5 clk = ~clk;

   task automatic check_vec(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vec_cnt++;
      if (obs !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic write_word(input logic [PRV_W-1:0] w);
      i_surv_valid  = 1'b1;
      i_surv_prv_st = w;
      tick();
      i_surv_valid  = 1'b0;
   endtask

   function automatic logic [PRV_W-1:0] map_identity();
      logic [PRV_W-1:0] w;
      for (int n = 0; n < 2**STATE_W; n++) w[n*STATE_W +: STATE_W] = STATE_W'(n);
      return w;
   endfunction

   function automatic logic [PRV_W-1:0] map_shift();
      logic [PRV_W-1:0] w;
      for (int n = 0; n < 2**STATE_W; n++) w[n*STATE_W +: STATE_W] = STATE_W'(n >> 2);
      return w;
   endfunction

   task automatic pulse_start(input logic [STATE_W-1:0] sel, input logic zt);
      i_tb_start  = 1'b1;
      i_sel_node  = sel;
      i_zero_term = zt;
      tick();
      i_tb_start  = 1'b0;
      i_zero_term = 1'b0;
   endtask

   // After an accepted start edge: o_valid low for 3 cycles, high on the 4th.
   task automatic wait_block(input string tag);
      for (int i = 1; i < TB_DEPTH; i++) begin
         tick();
         check_vec({tag, "_valid_early"}, 64'(o_valid), 64'd0);
      end
      tick();
      check_vec({tag, "_valid_lat"}, 64'(o_valid), 64'd1);
   endtask

   initial begin
      tick();
      tick();
      rst = 1'b0;
      check_vec("rst_busy",  64'(o_busy), 64'd0);
      check_vec("rst_valid", 64'(o_valid), 64'd0);
      check_vec("rst_data",  64'(o_decoder_data), 64'd0);
      check_vec("rst_final", 64'(o_final_node), 64'd0);
      check_vec("rst_ready", 64'(o_surv_ready), 64'd1);

      // Identity map: every step decodes sel[1:0]=3, final state stays 0xB.
      for (int k = 0; k < TB_DEPTH; k++) write_word(map_identity());
      check_vec("id_full_ready", 64'(o_surv_ready), 64'd0);
      pulse_start(4'hB, 1'b0);
      check_vec("id_busy", 64'(o_busy), 64'd1);
      wait_block("id");
      check_vec("id_data",  64'(o_decoder_data), 64'hFF);
      check_vec("id_final", 64'(o_final_node), 64'hB);
      i_ready = 1'b1;
      tick();
      i_ready = 1'b0;
      check_vec("id_rel_valid", 64'(o_valid), 64'd0);
      check_vec("id_rel_ready", 64'(o_surv_ready), 64'd1);

      // Shift map with start coinciding with the 4th write: dropped.
      for (int k = 0; k < TB_DEPTH-1; k++) write_word(map_shift());
      i_tb_start = 1'b1;
      i_sel_node = 4'hE;
      write_word(map_shift());
      i_tb_start = 1'b0;
      check_vec("st_drop_busy",  64'(o_busy), 64'd0);
      check_vec("st_full_ready", 64'(o_surv_ready), 64'd0);
      // Start next cycle together with a 5th write of junk: start taken, write ignored.
      i_surv_valid  = 1'b1;
      i_surv_prv_st = '1;
      pulse_start(4'hE, 1'b0);
      i_surv_valid  = 1'b0;
      check_vec("st_accept_busy", 64'(o_busy), 64'd1);
      check_vec("st_trace_ready", 64'(o_surv_ready), 64'd0);
      wait_block("sh");
      check_vec("sh_data",  64'(o_decoder_data), 64'hB0);
      check_vec("sh_final", 64'(o_final_node), 64'h0);

      // Back-pressure: block holds while i_ready is low; late start is ignored.
      i_tb_start = 1'b1;
      for (int c = 0; c < 5; c++) begin
         tick();
         check_vec("bp_valid", 64'(o_valid), 64'd1);
         check_vec("bp_data",  64'(o_decoder_data), 64'hB0);
         check_vec("bp_final", 64'(o_final_node), 64'h0);
         check_vec("bp_ready", 64'(o_surv_ready), 64'd0);
      end
      i_tb_start = 1'b0;
      i_ready = 1'b1;
      tick();
      i_ready = 1'b0;
      check_vec("bp_rel_valid", 64'(o_valid), 64'd0);
      check_vec("bp_rel_busy",  64'(o_busy), 64'd0);
      check_vec("bp_rel_ready", 64'(o_surv_ready), 64'd1);
      check_vec("bp_hold_data", 64'(o_decoder_data), 64'hB0);

      // Zero-termination ignores sel=0xF; refill proves fill restarted from 0.
      for (int k = 0; k < TB_DEPTH; k++) write_word(map_shift());
      pulse_start(4'hF, 1'b1);
      wait_block("zt");
      check_vec("zt_data",  64'(o_decoder_data), 64'h00);
      check_vec("zt_final", 64'(o_final_node), 64'h0);
      i_ready = 1'b1;
      tick();
      i_ready = 1'b0;

      // Reset two cycles into a trace aborts it.
      for (int k = 0; k < TB_DEPTH; k++) write_word(map_identity());
      pulse_start(4'hB, 1'b0);
      tick();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      check_vec("mr_busy",  64'(o_busy), 64'd0);
      check_vec("mr_valid", 64'(o_valid), 64'd0);
      check_vec("mr_data",  64'(o_decoder_data), 64'd0);
      check_vec("mr_ready", 64'(o_surv_ready), 64'd1);
      pulse_start(4'hB, 1'b0);
      check_vec("mr_start_busy", 64'(o_busy), 64'd0);
      for (int c = 0; c < TB_DEPTH+1; c++) tick();
      check_vec("mr_no_valid", 64'(o_valid), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule

// File: doc/traceback_engine.md
Name: traceback_engine

Overview:
- Parametrised successor to the single-path traceback unit in the Viterbi decoder datapath.
- Owns an internal survivor buffer written by the ACS stage, one trellis step per cycle.
- On a start command, traces back TB_DEPTH steps from a selected or zero-terminated state, then presents the decoded block through a valid/ready handshake.
- Adds buffering, back-pressure, a zero-termination mode and final-state reporting.

Parameters:
- STATE_W, 4, state register width; STATE_NUM = 2**STATE_W
- TB_DEPTH, 16, trellis steps per traceback block (>=2)
- OUT_BITS, 2, decoded bits per trellis step (<= STATE_W)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- i_surv_valid  in  1  survivor word valid
- o_surv_ready  out  1  survivor buffer can accept a word
- i_surv_prv_st  in  STATE_NUM*STATE_W  previous state of each state n, at bits [n*STATE_W +: STATE_W]
- i_tb_start  in  1  traceback start pulse
- i_sel_node  in  STATE_W  best end state, sampled on an accepted start
- i_zero_term  in  1  1 = start from state 0 and ignore i_sel_node; sampled with start
- o_busy  out  1  traceback or output pending
- o_valid  out  1  decoded block valid
- i_ready  in  1  consumer accepts block
- o_decoder_data  out  TB_DEPTH*OUT_BITS  decoded block; step s at [s*OUT_BITS +: OUT_BITS]; s=0 is the oldest step
- o_final_node  out  STATE_W  traced state before step 0, for block chaining

Behaviour:
- Reset: all outputs are 0 except o_surv_ready, which is 1. State=FILL, fill=0, buffer contents don't-care. A reset in any state aborts the operation and applies next edge.
- Sync reset is applied the same way when asserted mid-operation.
- States: FILL, TRACE, OUT.
- FILL:
  - o_surv_ready = (fill < TB_DEPTH).
  - When i_surv_valid && o_surv_ready, store the word at entry index fill, then fill++.
  - When fill == TB_DEPTH, writes are ignored.
  - i_tb_start is accepted only when fill == TB_DEPTH at that edge. Fill reaching TB_DEPTH on the same edge does not count; such a start is dropped, not queued. Starts are also ignored in TRACE/OUT.
  - Accept: node <= i_zero_term ? 0 : i_sel_node; idx <= TB_DEPTH-1; o_busy <= 1; go to TRACE.
- TRACE: o_surv_ready=0. Each cycle:
  - data[idx] <= node[OUT_BITS-1:0]
  - node <= entry[idx][node]
  - When idx == 0: o_final_node <= entry[0][node]; o_valid <= 1; go to OUT. Otherwise idx--.
- Latency: TB_DEPTH cycles from the accepted start edge to o_valid=1.
- OUT: o_valid=1. o_decoder_data and o_final_node are stable while i_ready=0. On o_valid && i_ready:
  - o_valid <= 0, o_busy <= 0, fill <= 0, go to FILL.
  - o_surv_ready is 1 in the next cycle.
  - o_decoder_data and o_final_node hold their last values until the next block.
- i_ready is ignored outside OUT.
- i_surv_valid is ignored outside FILL; no write occurs and no error is flagged.
- Node indexing into entry uses the full STATE_W bits; every node value is in range by construction.

Test Plan:
- Reset: assert rst 2 cycles mid-TRACE -> next cycle o_busy=0, o_valid=0, o_decoder_data=0, o_surv_ready=1. A following start with fill=0 is ignored.
- Identity map (TB_DEPTH=4): prv[n]=n for all entries; start with sel=0xB, zero_term=0 -> o_valid exactly 4 cycles after start, o_decoder_data=8'hFF, o_final_node=0xB.
- Shift map (TB_DEPTH=4): prv[n]=n>>2; sel=0xE -> step bits s3..s0 = 10,11,00,00; o_decoder_data=8'hB0; o_final_node=0x0.
- Zero-term: same shift map, sel=0xF, zero_term=1 -> o_decoder_data=8'h00, o_final_node=0.
- Start timing:
  - Start asserted on the edge of the 4th write -> ignored, o_busy stays 0.
  - Start the next cycle -> accepted.
  - A 5th write while full -> ignored, o_surv_ready=0.
- Back-pressure: hold i_ready=0 for 5 cycles in OUT -> o_valid=1, data stable, o_surv_ready=0. Raise i_ready -> next cycle o_valid=0, o_surv_ready=1, fill=0; a new 4-word fill then works.
